// File: rtl/inpkt_parser_pkg.sv
// Shared types and constants for the input packet parser.
// Holds the FSM state encoding, err_code values, header field positions
// and the packed payload word carried into the output register.
// The CSUM state exists only when INPKT_CHECKSUM_EN is defined.
package inpkt_parser_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned TYPE_W   = 8;
  localparam int unsigned ERR_W    = 2;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned ERRCNT_W = 8;

  // Header word layout: {version, type}
  localparam int unsigned VER_MSB  = 15;
  localparam int unsigned VER_LSB  = 8;
  localparam int unsigned TYPE_MSB = 7;
  localparam int unsigned TYPE_LSB = 0;

  localparam logic [ERR_W-1:0] ERR_BAD_HDR  = 2'd1;
  localparam logic [ERR_W-1:0] ERR_BAD_LEN  = 2'd2;
  localparam logic [ERR_W-1:0] ERR_BAD_CSUM = 2'd3;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_LEN  = 2'd1,
`ifdef INPKT_CHECKSUM_EN
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
`else
    ST_DATA = 2'd2
`endif
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              first;
    logic              last;
  } out_word_t;

endpackage

// File: rtl/inpkt_parser_if.sv
// Bus bundle for the packet parser: upstream FWFT FIFO read side,
// payload valid/ready stream, packet type, error pulse and counters.
// master: the parser; slave: FIFO/consumer environment.
interface inpkt_parser_if;
  import inpkt_parser_pkg::*;

  logic [WORD_W-1:0]   din;
  logic                empty;
  logic                rd_en;
  logic [WORD_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_first;
  logic                out_last;
  logic [TYPE_W-1:0]   out_type;
  logic                err_valid;
  logic [ERR_W-1:0]    err_code;
  logic [CNT_W-1:0]    pkt_count;
  logic [ERRCNT_W-1:0] err_count;

  modport master (
    input  din, empty, out_ready,
    output rd_en, out_data, out_valid, out_first, out_last,
           out_type, err_valid, err_code, pkt_count, err_count
  );

  modport slave (
    output din, empty, out_ready,
    input  rd_en, out_data, out_valid, out_first, out_last,
           out_type, err_valid, err_code, pkt_count, err_count
  );
endinterface

// File: rtl/inpkt_out_reg.sv
// Payload output register with valid/ready hold.
// Ports: clk, rst_n (async active-low), load/word (new word from the
// parser), ready (downstream accept), valid/held (registered output).
// The parser only loads when the register is empty or being drained,
// so a load in the same cycle as a transfer loses nothing.
module inpkt_out_reg
  import inpkt_parser_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  out_word_t word,
  input  logic      ready,
  output logic      valid,
  output out_word_t held
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      held  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      held  <= word;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inpkt_parser.sv
// Input packet parser: pops {header, length, payload[, checksum]} from a
// first-word-fall-through FIFO and streams the payload with first/last
// flags over a valid/ready interface, reporting malformed packets.
// Ports: CLK, rst_n (async active-low), bus (inpkt_parser_if.master).
// Build option: define INPKT_CHECKSUM_EN to expect and verify a trailing
// 16-bit wrap-around sum of the payload words.
module inpkt_parser
  import inpkt_parser_pkg::*;
#(
  parameter int unsigned PKT_MAX_LEN = 256,
  parameter logic [7:0]  PKT_VERSION = 8'h01
) (
  input logic            CLK,
  input logic            rst_n,
  inpkt_parser_if.master bus
);

  localparam int unsigned LEN_W = $clog2(PKT_MAX_LEN + 1);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                first_q, first_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  logic                run_q;
  logic                rd_en_c;
  logic                load;
  logic                err_set;
  logic [ERR_W-1:0]    err_sel;
  logic                pkt_inc;
  out_word_t           load_word;
  out_word_t           held;
  logic                o_valid;
  logic                err_valid_q;
  logic [ERR_W-1:0]    err_code_q;
  logic [CNT_W-1:0]    pkt_count_q;
  logic [ERRCNT_W-1:0] err_count_q;
`ifdef INPKT_CHECKSUM_EN
  logic [WORD_W-1:0]   acc_q, acc_d;
`endif

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HDR;
    else        state_q <= state_d;
  end

  // Next state, pop and per-word decisions; nothing is popped unless a word is present
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    first_d   = first_q;
    type_d    = type_q;
    rd_en_c   = 1'b0;
    load      = 1'b0;
    load_word = '0;
    err_set   = 1'b0;
    err_sel   = '0;
    pkt_inc   = 1'b0;
`ifdef INPKT_CHECKSUM_EN
    acc_d     = acc_q;
`endif
    if (run_q && !bus.empty) begin
      case (state_q)
        ST_HDR: begin
          rd_en_c = 1'b1;
          if (bus.din[VER_MSB:VER_LSB] == PKT_VERSION) begin
            type_d  = bus.din[TYPE_MSB:TYPE_LSB];
            state_d = ST_LEN;
          end else begin
            err_set = 1'b1;
            err_sel = ERR_BAD_HDR;
          end
        end
        ST_LEN: begin
          rd_en_c = 1'b1;
          if ((bus.din == '0) || (32'(bus.din) > PKT_MAX_LEN)) begin
            err_set = 1'b1;
            err_sel = ERR_BAD_LEN;
            state_d = ST_HDR;
          end else begin
            rem_d   = LEN_W'(bus.din);
            first_d = 1'b1;
`ifdef INPKT_CHECKSUM_EN
            acc_d   = '0;
`endif
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          // Pop only when the output register is free or draining this cycle
          if (!o_valid || bus.out_ready) begin
            rd_en_c         = 1'b1;
            load            = 1'b1;
            load_word.data  = bus.din;
            load_word.first = first_q;
            load_word.last  = (rem_q == LEN_W'(1));
            first_d         = 1'b0;
            rem_d           = rem_q - LEN_W'(1);
`ifdef INPKT_CHECKSUM_EN
            acc_d           = acc_q + bus.din;
            if (rem_q == LEN_W'(1)) state_d = ST_CSUM;
`else
            if (rem_q == LEN_W'(1)) begin
              state_d = ST_HDR;
              pkt_inc = 1'b1;
            end
`endif
          end
        end
`ifdef INPKT_CHECKSUM_EN
        ST_CSUM: begin
          rd_en_c = 1'b1;
          state_d = ST_HDR;
          if (bus.din == acc_q) begin
            pkt_inc = 1'b1;
          end else begin
            err_set = 1'b1;
            err_sel = ERR_BAD_CSUM;
          end
        end
`endif
        default: state_d = ST_HDR;
      endcase
    end
  end

  // Datapath registers, error pulse and counters
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      rem_q       <= '0;
      first_q     <= 1'b0;
      type_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
`ifdef INPKT_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      run_q       <= 1'b1;
      rem_q       <= rem_d;
      first_q     <= first_d;
      type_q      <= type_d;
      err_valid_q <= err_set;
      if (err_set) err_code_q <= err_sel;
      if (pkt_inc) pkt_count_q <= pkt_count_q + 16'd1;
      if (err_set && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
`ifdef INPKT_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  inpkt_out_reg u_out_reg (
    .clk   (CLK),
    .rst_n (rst_n),
    .load  (load),
    .word  (load_word),
    .ready (bus.out_ready),
    .valid (o_valid),
    .held  (held)
  );

  assign bus.rd_en     = rd_en_c;
  assign bus.out_valid = o_valid;
  assign bus.out_data  = held.data;
  assign bus.out_first = held.first;
  assign bus.out_last  = held.last;
  assign bus.out_type  = type_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;
  assign bus.pkt_count = pkt_count_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_inpkt_parser.sv
// Directed bench for inpkt_parser: a queue models the FWFT FIFO, a
// monitor records payload transfers and error pulses, and each test task
// compares against hand-computed values.
module tb_inpkt_parser;
  import inpkt_parser_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  inpkt_parser_if bus();

  inpkt_parser #(.PKT_MAX_LEN(256), .PKT_VERSION(8'h01)) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rd_viol = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: never
  bit          gap_mode = 1'b0;
  bit          gap;
  int          exp_pkts = 0;
  int          exp_errs = 0;
  logic [15:0] fifo[$];
  logic [15:0] pw[$];
  logic [17:0] got_q[$];
  int          got_t[$];
  logic [1:0]  err_q[$];

  // Upstream FIFO model: pop on rd_en, then present the new head
  always @(posedge clk) begin
    cyc++;
    if (bus.rd_en === 1'b1) begin
      if (bus.empty !== 1'b0) rd_viol++;
      else if (fifo.size() > 0) void'(fifo.pop_front());
    end
    #1;
    gap = gap_mode && ($urandom_range(0, 3) == 0);
    bus.empty = gap || (fifo.size() == 0);
    bus.din = (fifo.size() > 0) ? fifo[0] : 16'h0000;
  end

  // Consumer: drive ready, record transfers at the coming edge and error pulses
  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got_q.push_back({bus.out_data, bus.out_first, bus.out_last});
      got_t.push_back(cyc);
    end
    if (bus.err_valid === 1'b1) err_q.push_back(bus.err_code);
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic clear_obs;
    got_q.delete();
    got_t.delete();
    err_q.delete();
  endtask

  task automatic push_pkt(input logic [7:0] typ);
`ifdef INPKT_CHECKSUM_EN
    logic [15:0] sum;
    sum = 16'h0000;
    foreach (pw[i]) sum = sum + pw[i];
`endif
    fifo.push_back({8'h01, typ});
    fifo.push_back(16'(pw.size()));
    foreach (pw[i]) fifo.push_back(pw[i]);
`ifdef INPKT_CHECKSUM_EN
    fifo.push_back(sum);
`endif
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rdy_mode = 0;
    rst_n = 1'b0;
    fifo.push_back(16'h0107);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rd_en !== 1'b0) begin
      failures++; $display("FAIL reset_rd_en got=%0b exp=0", bus.rd_en);
    end
    checks++;
    if ({bus.out_valid, bus.out_first, bus.out_last, bus.out_data} !== 19'h0) begin
      failures++; $display("FAIL reset_out got=%0h exp=0", {bus.out_valid, bus.out_first, bus.out_last, bus.out_data});
    end
    checks++;
    if ({bus.out_type, bus.err_valid, bus.err_code} !== 11'h0) begin
      failures++; $display("FAIL reset_type_err got=%0h exp=0", {bus.out_type, bus.err_valid, bus.err_code});
    end
    checks++;
    if ({bus.pkt_count, bus.err_count} !== 24'h0) begin
      failures++; $display("FAIL reset_counts got=%0h exp=0", {bus.pkt_count, bus.err_count});
    end
    checks++;
    if (fifo.size() != 1) begin
      failures++; $display("FAIL reset_no_pop got=%0d exp=1", fifo.size());
    end
    fifo.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_obs();
  endtask

  task automatic test_basic;
    bit ok;
    clear_obs();
    pw = '{16'h1111, 16'h2222, 16'h3333};
    push_pkt(8'h07);
    exp_pkts = 1;
    wait_got(3, 100, ok);
    checks++;
    if (!ok || got_q.size() != 3) begin
      failures++; $display("FAIL basic_count got=%0d exp=3", got_q.size());
    end
    checks++;
    if (got_q[0] !== {16'h1111, 1'b1, 1'b0}) begin
      failures++; $display("FAIL basic_w0 got=%0h exp=%0h", got_q[0], {16'h1111, 1'b1, 1'b0});
    end
    checks++;
    if (got_q[1] !== {16'h2222, 1'b0, 1'b0}) begin
      failures++; $display("FAIL basic_w1 got=%0h exp=%0h", got_q[1], {16'h2222, 1'b0, 1'b0});
    end
    checks++;
    if (got_q[2] !== {16'h3333, 1'b0, 1'b1}) begin
      failures++; $display("FAIL basic_w2 got=%0h exp=%0h", got_q[2], {16'h3333, 1'b0, 1'b1});
    end
    checks++;
    if (got_t[2] - got_t[0] != 2) begin
      failures++; $display("FAIL basic_throughput got=%0d exp=2", got_t[2] - got_t[0]);
    end
    checks++;
    if (bus.out_type !== 8'h07) begin
      failures++; $display("FAIL basic_type got=%0h exp=07", bus.out_type);
    end
    checks++;
    if (bus.pkt_count !== 16'(exp_pkts)) begin
      failures++; $display("FAIL basic_pkt_count got=%0d exp=%0d", bus.pkt_count, exp_pkts);
    end
  endtask

  task automatic test_bad_header;
    bit ok;
    clear_obs();
    fifo.push_back(16'h0201);
    pw = '{16'hABCD};
    push_pkt(8'h05);
    exp_pkts++;
    exp_errs++;
    wait_got(1, 100, ok);
    checks++;
    if (err_q.size() != 1 || err_q[0] !== ERR_BAD_HDR) begin
      failures++; $display("FAIL badhdr_err got_n=%0d got_code=%0d exp_n=1 exp_code=1", err_q.size(), err_q[0]);
    end
    checks++;
    if (bus.err_count !== 8'(exp_errs)) begin
      failures++; $display("FAIL badhdr_err_count got=%0d exp=%0d", bus.err_count, exp_errs);
    end
    checks++;
    if (!ok || got_q.size() != 1 || got_q[0] !== {16'hABCD, 1'b1, 1'b1}) begin
      failures++; $display("FAIL badhdr_payload got=%0h n=%0d exp=%0h", got_q[0], got_q.size(), {16'hABCD, 1'b1, 1'b1});
    end
    checks++;
    if (bus.out_type !== 8'h05 || bus.pkt_count !== 16'(exp_pkts)) begin
      failures++; $display("FAIL badhdr_type_pkts got=%0h/%0d exp=05/%0d", bus.out_type, bus.pkt_count, exp_pkts);
    end
  endtask

  task automatic test_bad_len;
    clear_obs();
    fifo.push_back(16'h0103);
    fifo.push_back(16'h0000);
    fifo.push_back(16'h0103);
    fifo.push_back(16'h0101);
    exp_errs += 2;
    repeat (14) @(negedge clk);
    checks++;
    if (err_q.size() != 2 || err_q[0] !== ERR_BAD_LEN || err_q[1] !== ERR_BAD_LEN) begin
      failures++; $display("FAIL badlen_err got_n=%0d exp_n=2 code0=%0d code1=%0d exp=2", err_q.size(), err_q[0], err_q[1]);
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++; $display("FAIL badlen_no_out got=%0d exp=0", got_q.size());
    end
    checks++;
    if (bus.err_count !== 8'(exp_errs) || bus.pkt_count !== 16'(exp_pkts)) begin
      failures++; $display("FAIL badlen_counts got=%0d/%0d exp=%0d/%0d", bus.err_count, bus.pkt_count, exp_errs, exp_pkts);
    end
  endtask

  task automatic test_max_len;
    bit ok;
    int bad;
    clear_obs();
    pw.delete();
    for (int i = 0; i < 256; i++) pw.push_back(16'h0100 + 16'(i));
    push_pkt(8'h0C);
    exp_pkts++;
    wait_got(256, 600, ok);
    checks++;
    if (!ok || got_q.size() != 256) begin
      failures++; $display("FAIL maxlen_count got=%0d exp=256", got_q.size());
    end
    bad = 0;
    foreach (got_q[i])
      if (got_q[i] !== {16'h0100 + 16'(i), (i == 0), (i == 255)}) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL maxlen_words got_bad=%0d exp=0", bad);
    end
    checks++;
    if (bus.pkt_count !== 16'(exp_pkts) || err_q.size() != 0) begin
      failures++; $display("FAIL maxlen_pkts got=%0d errs=%0d exp=%0d errs=0", bus.pkt_count, err_q.size(), exp_pkts);
    end
  endtask

  task automatic test_hold;
    bit ok;
    int exp_left;
    clear_obs();
    rdy_mode = 2;
    pw = '{16'hAAAA};
    push_pkt(8'h11);
    pw = '{16'hB001, 16'hB002};
    push_pkt(8'h12);
    repeat (12) @(negedge clk);
`ifdef INPKT_CHECKSUM_EN
    exp_left = 3;
`else
    exp_left = 2;
`endif
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_first, bus.out_last} !== {1'b1, 16'hAAAA, 1'b1, 1'b1}) begin
      failures++; $display("FAIL hold_reg got=%0h exp=%0h", {bus.out_valid, bus.out_data, bus.out_first, bus.out_last}, {1'b1, 16'hAAAA, 1'b1, 1'b1});
    end
    checks++;
    if (fifo.size() != exp_left || bus.out_type !== 8'h12) begin
      failures++; $display("FAIL hold_next_hdr got_left=%0d type=%0h exp_left=%0d type=12", fifo.size(), bus.out_type, exp_left);
    end
    checks++;
    if (bus.pkt_count !== 16'(exp_pkts + 1)) begin
      failures++; $display("FAIL hold_pkt_count got=%0d exp=%0d", bus.pkt_count, exp_pkts + 1);
    end
    exp_pkts += 2;
    rdy_mode = 0;
    wait_got(3, 100, ok);
    checks++;
    if (!ok || got_q.size() != 3 || got_q[0] !== {16'hAAAA, 1'b1, 1'b1} ||
        got_q[1] !== {16'hB001, 1'b1, 1'b0} || got_q[2] !== {16'hB002, 1'b0, 1'b1}) begin
      failures++; $display("FAIL hold_release got=%0h %0h %0h n=%0d exp=%0h %0h %0h", got_q[0], got_q[1], got_q[2], got_q.size(),
        {16'hAAAA, 1'b1, 1'b1}, {16'hB001, 1'b1, 1'b0}, {16'hB002, 1'b0, 1'b1});
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [17:0] exp_w[6];
    clear_obs();
    exp_w = '{{16'hC001, 1'b1, 1'b0}, {16'hC002, 1'b0, 1'b0}, {16'hC003, 1'b0, 1'b0},
              {16'hC004, 1'b0, 1'b1}, {16'hD001, 1'b1, 1'b0}, {16'hD002, 1'b0, 1'b1}};
    pw = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
    push_pkt(8'h21);
    pw = '{16'hD001, 16'hD002};
    push_pkt(8'h22);
    exp_pkts += 2;
    wait_got(6, 100, ok);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_q[i] !== exp_w[i]) begin
        failures++; $display("FAIL b2b_w%0d got=%0h exp=%0h", i, got_q[i], exp_w[i]);
      end
    end
    checks++;
    if (!ok || got_t[3] - got_t[0] != 3 || bus.pkt_count !== 16'(exp_pkts)) begin
      failures++; $display("FAIL b2b_rate got_span=%0d pkts=%0d exp_span=3 pkts=%0d", got_t[3] - got_t[0], bus.pkt_count, exp_pkts);
    end
  endtask

`ifdef INPKT_CHECKSUM_EN
  task automatic test_checksum;
    bit ok;
    clear_obs();
    fifo.push_back(16'h0109); fifo.push_back(16'h0002);
    fifo.push_back(16'hFFFF); fifo.push_back(16'h0002); fifo.push_back(16'h0001);
    exp_pkts++;
    wait_got(2, 100, ok);
    checks++;
    if (!ok || bus.pkt_count !== 16'(exp_pkts) || err_q.size() != 0) begin
      failures++; $display("FAIL csum_good got_pkts=%0d errs=%0d exp=%0d errs=0", bus.pkt_count, err_q.size(), exp_pkts);
    end
    clear_obs();
    fifo.push_back(16'h0109); fifo.push_back(16'h0002);
    fifo.push_back(16'hFFFF); fifo.push_back(16'h0002); fifo.push_back(16'h0000);
    exp_errs++;
    wait_got(2, 100, ok);
    checks++;
    if (err_q.size() != 1 || err_q[0] !== ERR_BAD_CSUM) begin
      failures++; $display("FAIL csum_bad_err got_n=%0d code=%0d exp_n=1 code=3", err_q.size(), err_q[0]);
    end
    checks++;
    if (bus.pkt_count !== 16'(exp_pkts) || bus.err_count !== 8'(exp_errs)) begin
      failures++; $display("FAIL csum_bad_counts got=%0d/%0d exp=%0d/%0d", bus.pkt_count, bus.err_count, exp_pkts, exp_errs);
    end
    checks++;
    if (!ok || got_q[0] !== {16'hFFFF, 1'b1, 1'b0} || got_q[1] !== {16'h0002, 1'b0, 1'b1}) begin
      failures++; $display("FAIL csum_bad_payload got=%0h %0h exp=%0h %0h", got_q[0], got_q[1], {16'hFFFF, 1'b1, 1'b0}, {16'h0002, 1'b0, 1'b1});
    end
  endtask
`endif

  task automatic test_random;
    bit ok;
    int n;
    int bad;
    int first_bad;
    logic [15:0] w;
    logic [15:0] sum;
    logic [17:0] exp_q[$];
    clear_obs();
    rd_viol = 0;
    for (int p = 0; p < 1000; p++) begin
      n = $urandom_range(1, 6);
      fifo.push_back({8'h01, 8'($urandom)});
      fifo.push_back(16'(n));
      sum = 16'h0000;
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        sum = sum + w;
        fifo.push_back(w);
        exp_q.push_back({w, (i == 0), (i == n - 1)});
      end
`ifdef INPKT_CHECKSUM_EN
      fifo.push_back(sum);
`endif
    end
    exp_pkts += 1000;
    gap_mode = 1'b1;
    rdy_mode = 1;
    wait_got(exp_q.size(), 50000, ok);
    gap_mode = 1'b0;
    rdy_mode = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    bad = 0;
    first_bad = -1;
    foreach (exp_q[i]) begin
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL rand_words got_bad=%0d first=%0d exp_bad=0", bad, first_bad);
    end
    checks++;
    if (rd_viol != 0) begin
      failures++; $display("FAIL rand_rd_en_empty got=%0d exp=0", rd_viol);
    end
    checks++;
    if (bus.pkt_count !== 16'(exp_pkts) || bus.err_count !== 8'(exp_errs)) begin
      failures++; $display("FAIL rand_counts got=%0d/%0d exp=%0d/%0d", bus.pkt_count, bus.err_count, exp_pkts, exp_errs);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    clear_obs();
    pw.delete();
    for (int i = 0; i < 10; i++) pw.push_back(16'h5000 + 16'(i));
    push_pkt(8'h33);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (got_q.size() >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rstmid_start got=%0d exp=3", got_q.size());
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rd_en, bus.out_valid, bus.out_first, bus.out_last, bus.out_data, bus.out_type,
         bus.err_valid, bus.err_code, bus.pkt_count, bus.err_count} !== 55'h0) begin
      failures++; $display("FAIL rstmid_outputs got=%0h exp=0", {bus.rd_en, bus.out_valid, bus.out_first, bus.out_last,
        bus.out_data, bus.out_type, bus.err_valid, bus.err_code, bus.pkt_count, bus.err_count});
    end
    fifo.delete();
    clear_obs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_pkts = 1;
    exp_errs = 0;
    pw = '{16'h6001, 16'h6002};
    push_pkt(8'h44);
    wait_got(2, 100, ok);
    checks++;
    if (!ok || got_q.size() != 2 || got_q[0] !== {16'h6001, 1'b1, 1'b0} || got_q[1] !== {16'h6002, 1'b0, 1'b1}) begin
      failures++; $display("FAIL rstmid_next got=%0h %0h n=%0d exp=%0h %0h", got_q[0], got_q[1], got_q.size(),
        {16'h6001, 1'b1, 1'b0}, {16'h6002, 1'b0, 1'b1});
    end
    checks++;
    if (bus.out_type !== 8'h44 || bus.pkt_count !== 16'(exp_pkts) || err_q.size() != 0) begin
      failures++; $display("FAIL rstmid_state got=%0h/%0d errs=%0d exp=44/%0d errs=0", bus.out_type, bus.pkt_count, err_q.size(), exp_pkts);
    end
  endtask

  task automatic test_err_sat;
    clear_obs();
    for (int i = 0; i < 300; i++) fifo.push_back(16'h0000);
    repeat (320) @(negedge clk);
    checks++;
    if (err_q.size() != 300) begin
      failures++; $display("FAIL errsat_pulses got=%0d exp=300", err_q.size());
    end
    checks++;
    if (bus.err_count !== 8'hFF) begin
      failures++; $display("FAIL errsat_count got=%0h exp=ff", bus.err_count);
    end
    checks++;
    if (bus.pkt_count !== 16'(exp_pkts) || got_q.size() != 0) begin
      failures++; $display("FAIL errsat_side got=%0d out=%0d exp=%0d out=0", bus.pkt_count, got_q.size(), exp_pkts);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_header();
    test_bad_len();
    test_max_len();
    test_hold();
    test_back_to_back();
`ifdef INPKT_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    test_reset_mid();
    test_err_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
